cv32e40p_ft_manager: RTL and testbench
======================================

# cv32e40p_ft_manager

Central fault-tolerance manager for the triplicated (TMR) units of the core, such as the compressed decoder and ALU. It collects per-unit voter error pulses and replica-breakage status. It arbitrates simultaneous error events round-robin into an event-log FIFO read by the debug/CSR side. It also sequences software commands that force or release the `set_broken` state of individual replicas, guarding against configurations that would defeat voting.

## Interface
Parameters:
- N_UNITS, 4: number of managed TMR units (2..16)
- LOG_DEPTH, 4: event FIFO depth (power of 2, ≥2)
- CNT_W, 16: width of the total error counter
- ACK_TIMEOUT, 4: cycles to wait for `is_broken_i` to reflect a command

Ports (UW = $clog2(N_UNITS)):
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- err_detected_i  in  N_UNITS  per-unit voter mismatch pulse
- err_corrected_i  in  N_UNITS  per-unit "corrected by majority" pulse
- is_broken_i  in  N_UNITS×3  per-unit replica-broken mask, from the breakage monitors
- set_broken_o  out  N_UNITS×3  level force-broken request to the breakage monitors
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted this cycle (valid&ready)
- cmd_op_i  in  2  00 nop, 01 force-break, 10 release, 11 clear-sticky
- cmd_unit_i  in  UW  target unit
- cmd_replica_i  in  2  target replica 0..2 (3 = illegal)
- cmd_err_o  out  1  one-cycle pulse: command rejected or timed out
- log_valid_o / log_ready_i  out/in  1  event FIFO read handshake
- log_data_o  out  UW+4  {unit, corrected, broken_mask[2:0]}
- log_drop_o  out  1  sticky: an event was coalesced or lost
- fatal_o  out  1  sticky: some unit has ≥2 replicas broken
- err_cnt_o  out  CNT_W  saturating total of error pulses

## Operation
- **Pending flags.** Each unit has a pending flag, set on `err_detected_i`. The `corrected` attribute is ORed in while pending.
  - If `err_detected_i` arrives while the flag is already set, the event is coalesced and `log_drop_o` is set.
- **Arbiter.** Round-robin over pending units. It grants one unit per cycle when the FIFO is not full.
  - The pointer advances to granted+1.
  - On a grant, the FIFO is written with {unit, corrected, `is_broken_i[unit]`} and that unit's pending flag is cleared.
  - A new error on the same unit in the grant cycle re-sets the flag and does not count as a drop.
- **FIFO full.** Pending flags hold and no grant occurs.
- **Counter.** `err_cnt_o` += popcount(`err_detected_i`) every cycle, saturating at 2^CNT_W−1.
- **fatal_o.** Set when popcount(`is_broken_i[u]`) ≥ 2 for any u. Cleared only by reset.
- **Command FSM** (`cmd_ready_o` is high only in IDLE):
  - IDLE: accept the command.
    - clear-sticky clears `log_drop_o` and `err_cnt_o`, then stays in IDLE.
    - Reject with `cmd_err_o` and stay in IDLE if: replica = 3; or unit ≥ N_UNITS; or force-break would leave the unit with ≥2 replicas in (`set_broken_o` | `is_broken_i`).
    - Otherwise go to APPLY.
  - APPLY: set (force) or clear (release) `set_broken_o[unit][rep]`, load the timeout counter with ACK_TIMEOUT, go to WAIT.
  - WAIT:
    - Force: done when `is_broken_i[unit][rep]` = 1.
    - Release: done immediately. The breakage monitor decays on its own and no ack is required.
    - When done, go to IDLE.
    - On counter expiry, pulse `cmd_err_o`, keep `set_broken_o` as applied, and go to IDLE.
- A release of a replica that was not forced is legal and is a no-op.

## Timing
- **Reset values:** all outputs 0, FIFO empty, FSM in IDLE, RR pointer 0, pending flags 0.
- **Log latency:** error at cycle t → pending at t+1 → grant in t+1 → `log_valid_o` at t+2 (uncontended, FIFO not full).
- **FIFO read:** a pop on `log_valid_o`&`log_ready_i`. Simultaneous push and pop is allowed when full; the push succeeds. Data is first-word-fall-through from a registered array.
- **Command:** `cmd_ready_o` is a combinational function of the state. `set_broken_o` changes at the edge ending APPLY (accept+2). `cmd_err_o` is registered, one cycle after the decision.
- **Pulses:** `err_detected_i` and `err_corrected_i` are sampled every cycle, with no handshake. `fatal_o` is registered, one cycle after the condition.
- **Async reset mid-command:** `set_broken_o` clears immediately. The FSM returns to IDLE and in-flight log entries are discarded.

## Structure
- `cv32e40p_ft_pkg` holds:
  - the command-op enum `ft_cmd_op_e`
  - the FSM state enum `ft_mgr_state_e` (IDLE, APPLY, WAIT)
  - the `ft_log_entry_t` struct
  - defaults `FT_LOG_DEPTH` and `FT_ACK_TIMEOUT`
- One sub-module: `cv32e40p_ft_rr_arbiter` (N-request round-robin, grant one-hot plus index). The FIFO is inline.

## Test plan
- Simultaneous `err_detected_i` on units 0, 2 and 3 in one cycle, with `log_ready_i` = 1 → entries for units 0, 2, 3 appear on consecutive cycles starting at t+2; `err_cnt_o` = 3.
- With `log_ready_i` = 0, 6 single errors on distinct units (N=8, DEPTH=4) → FIFO holds 4 entries, 2 pending flags remain, `log_drop_o` = 0. After draining, all 6 entries are logged.
- Two errors on unit 1, 1 cycle apart, while the FIFO is full → `log_drop_o` = 1 and one entry is logged for unit 1. clear-sticky then clears `log_drop_o` and `err_cnt_o`.
- Force-break unit 2 replica 1, with the monitor echoing after 2 cycles → `set_broken_o[2][1]` = 1, no `cmd_err_o`, `cmd_ready_o` high again.
- With replica 1 of unit 2 forced, force replica 0 of unit 2 → rejected: `cmd_err_o` pulse, `set_broken_o` unchanged. With `is_broken_i` never echoing, a force on a clean replica → `cmd_err_o` after ACK_TIMEOUT cycles.
- Drive `is_broken_i[3]` = 3'b011 → `fatal_o` = 1 next cycle and it stays high. Assert `rst_n` = 0 mid-WAIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the TMR fault-tolerance manager: command ops, FSM states, log entries.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        FT_CMD_NOP     = 2'b00,
        FT_CMD_FORCE   = 2'b01,
        FT_CMD_RELEASE = 2'b10,
        FT_CMD_CLEAR   = 2'b11
    } ft_cmd_op_e;

    typedef enum logic [1:0] {
        FT_IDLE  = 2'd0,
        FT_APPLY = 2'd1,
        FT_WAIT  = 2'd2
    } ft_mgr_state_e;

    // Unit field sized for the largest supported configuration (16 units).
    localparam int unsigned FT_UNIT_W = 4;

    typedef struct packed {
        logic [FT_UNIT_W-1:0] unit;
        logic                 corrected;
        logic [2:0]           broken;
    } ft_log_entry_t;

    localparam int unsigned FT_LOG_DEPTH   = 4;
    localparam int unsigned FT_ACK_TIMEOUT = 4;

    function automatic logic [1:0] ft_popcnt3(input logic [2:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
    endfunction

endpackage

// File: rtl/cv32e40p_ft_manager_if.sv
// Command channel and event-log read channel of the fault-tolerance manager.
// Latency: n/a (wiring only).
// Backpressure: command uses valid/ready, log uses valid/ready with FWFT data.
interface cv32e40p_ft_manager_if #(
    parameter int unsigned N_UNITS = 4
);
    localparam int unsigned UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [UW-1:0] cmd_unit_i;
    logic [1:0]    cmd_replica_i;
    logic          cmd_err_o;
    logic          log_valid_o;
    logic          log_ready_i;
    logic [UW+3:0] log_data_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_unit_i, cmd_replica_i, log_ready_i,
        input  cmd_ready_o, cmd_err_o, log_valid_o, log_data_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_unit_i, cmd_replica_i, log_ready_i,
        output cmd_ready_o, cmd_err_o, log_valid_o, log_data_o
    );
endinterface

// File: rtl/cv32e40p_ft_rr_arbiter.sv
// Round-robin arbiter over N requesters; grant index plus one-hot, pointer moves to grant+1.
// Latency: combinational grant, pointer updates at the clock edge of a grant.
// Backpressure: en low suppresses the grant and freezes the pointer.
module cv32e40p_ft_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic [N-1:0]                          req,
    output logic                                  gnt_vld,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  gnt_idx,
    output logic [N-1:0]                          gnt_oh
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cand_idx;
    logic [IW-1:0] sel;
    logic          found;

    // Search starting at the pointer; the first requester in rotation order wins.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_idx = IW'((32'(ptr_q) + k) % N);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    assign gnt_vld = en & found;
    assign gnt_idx = sel;
    assign gnt_oh  = gnt_vld ? (N'(1) << sel) : '0;

    // Pointer advances past the granted requester, wrapping at N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (gnt_vld) begin
            ptr_q <= (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_ft_manager.sv
// TMR fault manager: error pending flags -> RR arbiter -> event FIFO; replica force/release sequencer.
// Latency: error at t logged at t+2; command set_broken at accept+2, err pulse one cycle after decision.
// Backpressure: full FIFO holds pending flags (re-errors coalesce); cmd_ready only in IDLE.
module cv32e40p_ft_manager
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned N_UNITS     = 4,
    parameter int unsigned LOG_DEPTH   = FT_LOG_DEPTH,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ACK_TIMEOUT = FT_ACK_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_UNITS-1:0]        err_detected_i,
    input  logic [N_UNITS-1:0]        err_corrected_i,
    input  logic [N_UNITS-1:0][2:0]   is_broken_i,
    output logic [N_UNITS-1:0][2:0]   set_broken_o,
    output logic                      log_drop_o,
    output logic                      fatal_o,
    output logic [CNT_W-1:0]          err_cnt_o,
    cv32e40p_ft_manager_if.slave      bus
);
    localparam int unsigned UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int unsigned AW = $clog2(LOG_DEPTH);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    logic [N_UNITS-1:0] pend_q, corr_q, keep, gnt_oh;
    logic               gnt_vld, arb_en, push, pop, full, drop_evt, fatal_evt;
    logic [UW-1:0]      gnt_idx;
    ft_log_entry_t      mem_q [LOG_DEPTH];
    ft_log_entry_t      wr_entry, head;
    logic [AW-1:0]      wptr_q, rptr_q;
    logic [AW:0]        fill_q;
    logic [CNT_W:0]     det_cnt, cnt_sum;

    ft_mgr_state_e      state_q;
    ft_cmd_op_e         op;
    logic [UW-1:0]      unit_q;
    logic [1:0]         rep_q;
    logic               force_q, cmd_err_q, accept, clr, reject;
    logic [TW-1:0]      tmo_q;
    logic [2:0]         tgt_mask;

    // ---------------- event path ----------------
    assign full     = (fill_q == (AW+1)'(LOG_DEPTH));
    assign pop      = bus.log_valid_o & bus.log_ready_i;
    // A pop in the same cycle frees the slot, so a grant may still land.
    assign arb_en   = ~full | pop;
    assign push     = gnt_vld;
    assign keep     = pend_q & ~gnt_oh;
    assign drop_evt = |(err_detected_i & keep);

    cv32e40p_ft_rr_arbiter #(.N(N_UNITS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .req     (pend_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt_oh  (gnt_oh)
    );

    assign wr_entry.unit      = FT_UNIT_W'(gnt_idx);
    assign wr_entry.corrected = corr_q[gnt_idx];
    assign wr_entry.broken    = is_broken_i[gnt_idx];

    // Pending flags: grant clears, a new error (re)sets, corrected accumulates while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            corr_q <= '0;
        end else begin
            pend_q <= keep | err_detected_i;
            corr_q <= (corr_q & keep) | (err_corrected_i & (keep | err_detected_i));
        end
    end

    // FIFO storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_entry;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            fill_q <= fill_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head            = mem_q[rptr_q];
    assign bus.log_valid_o = (fill_q != '0);
    assign bus.log_data_o  = {UW'(head.unit), head.corrected, head.broken};

    // Error popcount and fatal (two or more replicas broken in any unit).
    always_comb begin
        det_cnt   = '0;
        fatal_evt = 1'b0;
        for (int u = 0; u < N_UNITS; u++) begin
            det_cnt = det_cnt + (CNT_W+1)'(err_detected_i[u]);
            if (ft_popcnt3(is_broken_i[u]) >= 2'd2) fatal_evt = 1'b1;
        end
        cnt_sum = {1'b0, err_cnt_o} + det_cnt;
    end

    // Sticky status and saturating counter; clear-sticky wins over same-cycle events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_o  <= '0;
            log_drop_o <= 1'b0;
            fatal_o    <= 1'b0;
        end else begin
            if (clr) begin
                err_cnt_o  <= '0;
                log_drop_o <= 1'b0;
            end else begin
                err_cnt_o <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                if (drop_evt) log_drop_o <= 1'b1;
            end
            if (fatal_evt) fatal_o <= 1'b1;
        end
    end

    // ---------------- command path ----------------
    assign op              = ft_cmd_op_e'(bus.cmd_op_i);
    assign bus.cmd_ready_o = (state_q == FT_IDLE);
    assign bus.cmd_err_o   = cmd_err_q;
    assign accept          = bus.cmd_valid_i & bus.cmd_ready_o;
    assign clr             = accept & (op == FT_CMD_CLEAR);

    // Reject illegal targets, and forces that would leave voting with under two healthy replicas.
    always_comb begin
        tgt_mask = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (bus.cmd_unit_i == UW'(u)) tgt_mask = set_broken_o[u] | is_broken_i[u];
        end
        reject = (bus.cmd_replica_i == 2'd3)
              || ({1'b0, bus.cmd_unit_i} >= (UW+1)'(N_UNITS))
              || ((op == FT_CMD_FORCE)
                  && (ft_popcnt3(tgt_mask | (3'b001 << bus.cmd_replica_i)) >= 2'd2));
    end

    // Command sequencer: IDLE decides, APPLY drives set_broken, WAIT collects the ack or times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FT_IDLE;
            unit_q       <= '0;
            rep_q        <= '0;
            force_q      <= 1'b0;
            tmo_q        <= '0;
            set_broken_o <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            case (state_q)
                FT_IDLE: begin
                    if (accept && (op == FT_CMD_FORCE || op == FT_CMD_RELEASE)) begin
                        if (reject) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            unit_q  <= bus.cmd_unit_i;
                            rep_q   <= bus.cmd_replica_i;
                            force_q <= (op == FT_CMD_FORCE);
                            state_q <= FT_APPLY;
                        end
                    end
                end
                FT_APPLY: begin
                    set_broken_o[unit_q][rep_q] <= force_q;
                    tmo_q   <= TW'(ACK_TIMEOUT);
                    state_q <= FT_WAIT;
                end
                FT_WAIT: begin
                    // Releases need no ack: the monitor decays on its own.
                    if (!force_q || is_broken_i[unit_q][rep_q]) begin
                        state_q <= FT_IDLE;
                    end else if (tmo_q == TW'(1)) begin
                        cmd_err_q <= 1'b1;
                        state_q   <= FT_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                default: state_q <= FT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_ft_manager.sv
// Directed bench for the fault manager with a queue-based reference model checked every cycle.
// Latency: n/a (testbench).
// Backpressure: drives log_ready_i explicitly per scenario.
`timescale 1ns/1ps
module tb_cv32e40p_ft_manager;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int CW = 16;
    localparam int T  = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        err_det, err_corr;
    logic [N-1:0][2:0]   is_broken, set_broken, isb_force, sb_d1, sb_d2;
    logic                echo_en;
    logic                log_drop, fatal;
    logic [CW-1:0]       err_cnt;

    int tests = 0;
    int fails = 0;
    int err_pulses = 0;

    cv32e40p_ft_manager_if #(.N_UNITS(N)) bus ();

    cv32e40p_ft_manager #(
        .N_UNITS(N), .LOG_DEPTH(D), .CNT_W(CW), .ACK_TIMEOUT(T)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .err_detected_i  (err_det),
        .err_corrected_i (err_corr),
        .is_broken_i     (is_broken),
        .set_broken_o    (set_broken),
        .log_drop_o      (log_drop),
        .fatal_o         (fatal),
        .err_cnt_o       (err_cnt),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Breakage monitor stand-in: echoes set_broken two cycles later when enabled.
    assign is_broken = (echo_en ? sb_d2 : '0) | isb_force;
    always @(negedge clk) begin
        sb_d2 = sb_d1;
        sb_d1 = set_broken;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int                m_q[$];
    bit                m_pend[N];
    bit                m_corr[N];
    int                m_ptr, m_cnt, m_age, m_unit, m_rep;
    bit                m_drop, m_fatal, m_force, m_err;
    logic [N-1:0][2:0] m_set;

    task automatic model_reset();
        m_q.delete();
        for (int u = 0; u < N; u++) begin m_pend[u] = 0; m_corr[u] = 0; end
        m_ptr = 0; m_cnt = 0; m_age = 0; m_unit = 0; m_rep = 0;
        m_drop = 0; m_fatal = 0; m_force = 0; m_err = 0; m_set = '0;
    endtask

    task automatic model_step();
        bit pop, can;
        int g;
        logic [2:0] msk;
        pop = (m_q.size() > 0) && bus.log_ready_i;
        can = (m_q.size() < D) || pop;
        g = -1;
        if (can)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back((g << 4) | (int'(m_corr[g]) << 3) | int'(is_broken[g]));
            m_ptr = (g + 1) % N;
        end
        for (int u = 0; u < N; u++) begin
            bit held;
            held = m_pend[u] && (u != g);
            if (err_det[u]) begin
                if (held) m_drop = 1;
                m_corr[u] = (held && m_corr[u]) || err_corr[u];
                m_pend[u] = 1;
            end else if (held) begin
                m_corr[u] = m_corr[u] || err_corr[u];
            end else begin
                m_pend[u] = 0;
                m_corr[u] = 0;
            end
        end
        m_cnt = m_cnt + $countones(err_det);
        if (m_cnt > 65535) m_cnt = 65535;
        for (int u = 0; u < N; u++) if ($countones(is_broken[u]) >= 2) m_fatal = 1;
        // Command: m_age counts cycles since acceptance (0 = idle).
        m_err = 0;
        if (m_age == 0) begin
            if (bus.cmd_valid_i) begin
                if (bus.cmd_op_i == 2'd3) begin
                    m_cnt = 0;
                    m_drop = 0;
                end else if (bus.cmd_op_i != 2'd0) begin
                    msk = m_set[bus.cmd_unit_i] | is_broken[bus.cmd_unit_i];
                    if (bus.cmd_replica_i == 2'd3 || int'(bus.cmd_unit_i) >= N) m_err = 1;
                    else if (bus.cmd_op_i == 2'd1 &&
                             $countones(msk | (3'b001 << bus.cmd_replica_i)) >= 2) m_err = 1;
                    else begin
                        m_unit  = int'(bus.cmd_unit_i);
                        m_rep   = int'(bus.cmd_replica_i);
                        m_force = (bus.cmd_op_i == 2'd1);
                        m_age   = 1;
                    end
                end
            end
        end else if (m_age == 1) begin
            m_set[m_unit][m_rep] = m_force;
            m_age = 2;
        end else begin
            if (!m_force || is_broken[m_unit][m_rep]) m_age = 0;
            else if (m_age == T + 1) begin m_err = 1; m_age = 0; end
            else m_age++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (bus.cmd_err_o === 1'b1) err_pulses++;
        chk("cmd_ready", bus.cmd_ready_o, m_age == 0);
        chk("cmd_err", bus.cmd_err_o, m_err);
        chk("log_valid", bus.log_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) chk("log_data", bus.log_data_o, m_q[0]);
        chk("log_drop", log_drop, m_drop);
        chk("fatal", fatal, m_fatal);
        chk("err_cnt", err_cnt, m_cnt);
        chk("set_broken", set_broken, m_set);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int unit, input int rep);
        chk("cmd_ready_before_send", bus.cmd_ready_o, 1);
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_op_i      = op;
        bus.cmd_unit_i    = 3'(unit);
        bus.cmd_replica_i = 2'(rep);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    initial begin
        logic [6:0] got[$];
        logic [6:0] exp_seq [7];
        int pc, ep0;
        exp_seq = '{7'h40, 7'h50, 7'h00, 7'h18, 7'h20, 7'h30, 7'h10};

        rst_n = 1'b0; err_det = '0; err_corr = '0; isb_force = '0; echo_en = 1'b1;
        sb_d1 = '0; sb_d2 = '0;
        bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'd0; bus.cmd_unit_i = '0;
        bus.cmd_replica_i = 2'd0; bus.log_ready_i = 1'b1;
        cyc(2);
        chk("reset_cnt", err_cnt, 0);
        chk("reset_log_valid", bus.log_valid_o, 0);
        chk("reset_set_broken", set_broken, 0);
        chk("reset_fatal", fatal, 0);
        rst_n = 1'b1;
        cyc(1);

        // Simultaneous errors on units 0, 2, 3.
        err_det = 8'b0000_1101; cyc(1); err_det = '0;
        chk("t1_cnt", err_cnt, 3);
        chk("t1_valid_t1", bus.log_valid_o, 0);
        cyc(1); chk("t1_entry_u0", {bus.log_valid_o, bus.log_data_o}, 8'h80);
        cyc(1); chk("t1_entry_u2", {bus.log_valid_o, bus.log_data_o}, 8'hA0);
        cyc(1); chk("t1_entry_u3", {bus.log_valid_o, bus.log_data_o}, 8'hB0);
        cyc(1); chk("t1_empty", bus.log_valid_o, 0);

        // Six errors with the reader stalled: four logged, two pending.
        bus.log_ready_i = 1'b0;
        err_det = 8'b0011_1111; err_corr = 8'b0000_0010; cyc(1);
        err_det = '0; err_corr = '0;
        cyc(6);
        chk("t2_head", {bus.log_valid_o, bus.log_data_o}, 8'hC0);
        pc = 0;
        for (int u = 0; u < N; u++) pc += int'(m_pend[u]);
        chk("t2_model_pending", pc, 2);
        chk("t2_drop", log_drop, 0);
        chk("t2_cnt", err_cnt, 9);

        // Back-to-back errors on unit 1 while full coalesce.
        err_det = 8'b0000_0010; cyc(1);
        err_det = 8'b0000_0010; cyc(1);
        err_det = '0;
        chk("t3_drop", log_drop, 1);
        chk("t3_cnt", err_cnt, 11);
        bus.log_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.log_valid_o) got.push_back(bus.log_data_o);
            cyc(1);
        end
        chk("t3_drain_count", got.size(), 7);
        for (int i = 0; i < 7 && i < got.size(); i++) chk("t3_drain_entry", got[i], exp_seq[i]);

        send_cmd(2'd3, 0, 0);
        chk("clear_drop", log_drop, 0);
        chk("clear_cnt", err_cnt, 0);

        // Force unit 2 replica 1 with the monitor echoing.
        ep0 = err_pulses;
        send_cmd(2'd1, 2, 1);
        cyc(8);
        chk("t4_set_broken", set_broken, 24'h000080);
        chk("t4_ready", bus.cmd_ready_o, 1);
        chk("t4_no_err", err_pulses - ep0, 0);

        // Second replica of the same unit is refused.
        send_cmd(2'd1, 2, 0);
        chk("t5_reject_err", bus.cmd_err_o, 1);
        chk("t5_reject_sb", set_broken, 24'h000080);
        cyc(1); chk("t5_err_pulse_end", bus.cmd_err_o, 0);
        send_cmd(2'd2, 4, 3);
        chk("t5_bad_replica", bus.cmd_err_o, 1);

        // No echo: force times out after the ack window.
        echo_en = 1'b0; cyc(1);
        send_cmd(2'd1, 5, 2);
        cyc(4); chk("t5_tmo_early", bus.cmd_err_o, 0);
        cyc(1); chk("t5_tmo_err", bus.cmd_err_o, 1);
        chk("t5_tmo_sb_kept", set_broken, 24'h020080);
        send_cmd(2'd2, 5, 2);
        cyc(3); chk("t5_release", set_broken, 24'h000080);

        // Two broken replicas on unit 3 raise sticky fatal.
        chk("t6_fatal_before", fatal, 0);
        isb_force[3] = 3'b011; cyc(1);
        chk("t6_fatal_set", fatal, 1);
        isb_force = '0; cyc(3);
        chk("t6_fatal_sticky", fatal, 1);

        // Async reset while a force is waiting for its ack.
        bus.log_ready_i = 1'b0;
        err_det = 8'h80; cyc(1); err_det = '0;
        send_cmd(2'd1, 6, 0);
        cyc(1);
        chk("rst_pre_sb", set_broken, 24'h040080);
        chk("rst_pre_busy", bus.cmd_ready_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sb", set_broken, 0);
        chk("rst_log_valid", bus.log_valid_o, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_fatal", fatal, 0);
        chk("rst_drop", log_drop, 0);
        chk("rst_cmd_err", bus.cmd_err_o, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
